// File: rtl/cgra_data_bus_responder.sv
// Memory-side responder for the CGRA column data bus: round-robin arbitration of N_PORTS
// initiators onto one single-port word SRAM bank with a fixed 1-cycle response.
module cgra_data_bus_responder #(
  parameter int                   N_PORTS    = 4,
  parameter int                   ADD_WIDTH  = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   MEM_DEPTH  = 1024,
  parameter logic [ADD_WIDTH-1:0] BASE_ADDR  = {ADD_WIDTH{1'b0}}
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [N_PORTS-1:0]                    bus_data_req_i,
  input  logic [N_PORTS-1:0][ADD_WIDTH-1:0]     bus_data_add_i,
  input  logic [N_PORTS-1:0]                    bus_data_wen_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]  bus_data_be_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    bus_data_wdata_i,
  input  logic                                  stall_i,
  output logic [N_PORTS-1:0]                    bus_data_gnt_o,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    bus_data_rdata_o,
  output logic [N_PORTS-1:0]                    bus_r_valid_o,
  output logic [N_PORTS-1:0]                    bus_err_o
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [PTR_W-1:0]                 rr_ptr_r;
  logic [N_PORTS-1:0]               valid_r;
  logic [N_PORTS-1:0]               err_r;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] rdata_r;
  logic [DATA_WIDTH-1:0]            mem_r [MEM_DEPTH];

  logic [N_PORTS-1:0]               gnt_s;
  logic [PTR_W-1:0]                 gnt_idx_s;
  logic                             gnt_any_s;
  logic [PTR_W-1:0]                 rr_next_s;
  logic [ADD_WIDTH-1:0]             off_s;
  logic [IDX_W-1:0]                 word_s;
  logic                             in_range_s;
  logic                             wr_en_s;
  logic                             rd_en_s;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int step);
    return PTR_W'((int'(base) + step) % N_PORTS);
  endfunction

  // Round-robin grant: first requester at or after rr_ptr, nothing while stalled or in reset
  always_comb begin
    gnt_s     = {N_PORTS{1'b0}};
    gnt_idx_s = {PTR_W{1'b0}};
    gnt_any_s = 1'b0;
    if (!stall_i && !rst_i) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!gnt_any_s && bus_data_req_i[wrap_idx(rr_ptr_r, k)]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = wrap_idx(rr_ptr_r, k);
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
      if (gnt_any_s) begin
        gnt_s[gnt_idx_s] = 1'b1;
      end else begin
        gnt_s = {N_PORTS{1'b0}};
      end
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // Decode of the granted port's address and access type
  always_comb begin
    off_s      = bus_data_add_i[gnt_idx_s] - BASE_ADDR;
    word_s     = off_s[IDX_W+1:2];
    in_range_s = (off_s < ADD_WIDTH'(MEM_DEPTH * 4));
    wr_en_s    = gnt_any_s & ~bus_data_wen_i[gnt_idx_s] & in_range_s;
    rd_en_s    = gnt_any_s & bus_data_wen_i[gnt_idx_s];
    if (gnt_idx_s == PTR_W'(N_PORTS - 1)) begin
      rr_next_s = {PTR_W{1'b0}};
    end else begin
      rr_next_s = gnt_idx_s + PTR_W'(1);
    end
  end

  // Byte-masked write into the bank; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus_data_be_i[gnt_idx_s][b]) begin
          mem_r[word_s][b*8 +: 8] <= bus_data_wdata_i[gnt_idx_s][b*8 +: 8];
        end
      end
    end
  end

  // Arbiter pointer, response pipeline and per-port held read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      valid_r  <= {N_PORTS{1'b0}};
      err_r    <= {N_PORTS{1'b0}};
      rdata_r  <= {(N_PORTS*DATA_WIDTH){1'b0}};
    end else begin
      valid_r <= gnt_s;
      err_r   <= gnt_s & {N_PORTS{~in_range_s}};
      if (gnt_any_s) begin
        rr_ptr_r <= rr_next_s;
      end
      if (rd_en_s) begin
        rdata_r[gnt_idx_s] <= in_range_s ? mem_r[word_s] : {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign bus_data_gnt_o   = gnt_s;
  assign bus_r_valid_o    = valid_r;
  assign bus_err_o        = err_r;
  assign bus_data_rdata_o = rdata_r;

  cgra_data_bus_responder_chk #(.N_PORTS(N_PORTS)) u_chk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (bus_data_req_i),
    .gnt   (gnt_s)
  );

endmodule

// Grant sanity properties for the responder arbiter.
module cgra_data_bus_responder_chk #(
  parameter int N_PORTS = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic [N_PORTS-1:0] req,
  input logic [N_PORTS-1:0] gnt
);

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt));
  a_gnt_has_req: assert property (@(posedge clk_i) disable iff (rst_i) (gnt & ~req) == {N_PORTS{1'b0}});

endmodule
